counter_uart_tx: RTL and testbench



---
 rtl/counter_pkg.sv | 15 +
 rtl/uart_bit_timer.sv | 29 ++
 rtl/counter_uart_tx.sv | 123 ++++++++++++
 tb/tb_counter_uart_tx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter UART transmitter.
// Holds the frame FSM state encoding and frame geometry.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_bit_timer.sv
// Baud timer: bit_end pulses for one cycle every CLKS_PER_BIT cycles while run is high.
// Ports: clk, rst (async, active-high), run (enable, clears when low) -> bit_end.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_end
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = run && (cnt == LAST);

endmodule

// File: rtl/counter_uart_tx.sv
// Snapshots count_in and sends it as one UART 8N1 frame on request or periodic tick.
// Ports: clk, rst, count_in[7:0], send, auto_en -> tx, busy, done, overrun.
module counter_uart_tx
  import counter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int AUTO_PERIOD  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count_in,
  input  logic       send,
  input  logic       auto_en,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [AW-1:0] auto_cnt;
  logic          auto_tick;
  logic          trigger;
  logic          trig_q;
  logic          trig_rise;
  logic          bit_end;
  logic          frame_end;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      auto_cnt <= '0;
    end else if (!auto_en || auto_cnt == AUTO_LAST) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign auto_tick = auto_en && (auto_cnt == AUTO_LAST);
  assign trigger   = send | auto_tick;
  // A held request is one request; only a new one can be refused.
  assign trig_rise = trigger & ~trig_q;
  // The STOP boundary also accepts a trigger so frames chain without a gap.
  assign frame_end = (state == STOP) && bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      done   <= 1'b0;
      trig_q <= trigger;
      unique case (state)
        IDLE: begin
          if (trigger) begin
            state <= START;
            shreg <= count_in;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            done <= 1'b1;
            if (trigger) begin
              state <= START;
              shreg <= count_in;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
      endcase
      if (state != IDLE && trig_rise && !frame_end) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_uart_tx.sv
// Self-checking bench for counter_uart_tx with CLKS_PER_BIT=4, AUTO_PERIOD=64.
// Expected line levels come from a bit-index model of an 8N1 frame.
module tb_counter_uart_tx;

  localparam int C     = 4;
  localparam int P     = 64;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] count_in = '0;
  logic       send = 1'b0;
  logic       auto_en = 1'b0;
  logic       tx;
  logic       busy;
  logic       done;
  logic       overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  counter_uart_tx #(
    .CLKS_PER_BIT(C),
    .AUTO_PERIOD (P)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .count_in(count_in),
    .send    (send),
    .auto_en (auto_en),
    .tx      (tx),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line level k cycles after the start edge of a frame carrying b.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    idx = k / C;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({tx, busy, done, overrun} !== 4'b1000)
      $display("FAIL reset_hold got %b want 1000", {tx, busy, done, overrun});
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if ({tx, busy, done, overrun} !== 4'b1000)
      $display("FAIL reset_release got %b want 1000", {tx, busy, done, overrun});
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [7:0] b;
    logic       e;
    for (int f = 0; f < 4; f++) begin
      b = (f == 0) ? 8'hA5 : 8'($urandom);
      count_in = b;
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        count_in = 8'($urandom);
        e = exp_tx(b, k);
        total_cnt++;
        if ({tx, busy, done} !== {e, 2'b10})
          $display("FAIL basic b=%h k=%0d got %b want %b", b, k,
                   {tx, busy, done}, {e, 2'b10});
        else pass_cnt++;
        tick();
      end
      total_cnt++;
      if ({tx, busy, done} !== 3'b101)
        $display("FAIL basic_done b=%h got %b want 101", b, {tx, busy, done});
      else pass_cnt++;
      tick();
      total_cnt++;
      if ({tx, busy, done} !== 3'b100)
        $display("FAIL basic_after got %b want 100", {tx, busy, done});
      else pass_cnt++;
    end
  endtask

  task automatic test_mid_change();
    logic e;
    for (int f = 0; f < 2; f++) begin
      count_in = 8'h3C;
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (k == 5) count_in = 8'hFF;
        if (f == 1 && k == FRAME - 1) send = 1'b1;
        e = exp_tx(8'h3C, k);
        total_cnt++;
        if ({tx, busy} !== {e, 1'b1})
          $display("FAIL mid_change f=%0d k=%0d got %b want %b", f, k,
                   {tx, busy}, {e, 1'b1});
        else pass_cnt++;
        tick();
      end
      send = 1'b0;
      if (f == 0) begin
        total_cnt++;
        if ({tx, busy, done} !== 3'b101)
          $display("FAIL mid_idle_done got %b want 101", {tx, busy, done});
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({tx, busy, done} !== 3'b100)
          $display("FAIL mid_no_restart got %b want 100", {tx, busy, done});
        else pass_cnt++;
      end else begin
        total_cnt++;
        if ({tx, busy, done} !== 3'b011)
          $display("FAIL mid_chain_start got %b want 011", {tx, busy, done});
        else pass_cnt++;
      end
    end
    for (int k = 0; k < FRAME; k++) begin
      e = exp_tx(8'hFF, k);
      total_cnt++;
      if ({tx, busy} !== {e, 1'b1})
        $display("FAIL mid_chain k=%0d got %b want %b", k, {tx, busy}, {e, 1'b1});
      else pass_cnt++;
      tick();
    end
    total_cnt++;
    if ({tx, busy, done, overrun} !== 4'b1010)
      $display("FAIL mid_chain_done got %b want 1010", {tx, busy, done, overrun});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] b;
    logic       e;
    for (int f = 0; f < 2; f++) begin
      b = (f == 0) ? 8'h5A : 8'($urandom);
      count_in = b;
      send = 1'b1;
      tick();
      send = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
        if (f == 0 && k == 10) send = 1'b1;
        if (f == 0 && k == 11) send = 1'b0;
        e = exp_tx(b, k);
        total_cnt++;
        if ({tx, busy} !== {e, 1'b1})
          $display("FAIL overrun_frame f=%0d k=%0d got %b want %b", f, k,
                   {tx, busy}, {e, 1'b1});
        else pass_cnt++;
        tick();
      end
      total_cnt++;
      if ({tx, busy, done, overrun} !== 4'b1011)
        $display("FAIL overrun_sticky f=%0d got %b want 1011", f,
                 {tx, busy, done, overrun});
      else pass_cnt++;
      tick();
    end
    rst = 1'b1;
    #1;
    total_cnt++;
    if (overrun !== 1'b0)
      $display("FAIL overrun_clear got %b want 0", overrun);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_auto();
    int  n;
    int  bc;
    logic e;
    count_in = 8'h01;
    auto_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 200);
    total_cnt++;
    if (n !== P) $display("FAIL auto_first got %0d want %0d", n, P);
    else pass_cnt++;
    for (int k = 0; k < FRAME; k++) begin
      e = exp_tx(8'h01, k);
      total_cnt++;
      if ({tx, busy} !== {e, 1'b1})
        $display("FAIL auto_frame k=%0d got %b want %b", k, {tx, busy}, {e, 1'b1});
      else pass_cnt++;
      tick();
    end
    n = FRAME;
    do begin tick(); n++; end while (!busy && n < 200);
    total_cnt++;
    if (n !== P) $display("FAIL auto_period got %0d want %0d", n, P);
    else pass_cnt++;
    for (int k = 0; k < 45; k++) tick();
    auto_en = 1'b0;
    bc = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (busy) bc++;
    end
    total_cnt++;
    if (bc !== 0) $display("FAIL auto_disable got %0d busy cycles want 0", bc);
    else pass_cnt++;
    auto_en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!busy && n < 200);
    total_cnt++;
    if (n !== P) $display("FAIL auto_reenable got %0d want %0d", n, P);
    else pass_cnt++;
    auto_en = 1'b0;
    for (int k = 0; k < FRAME + 2; k++) tick();
    total_cnt++;
    if ({busy, overrun} !== 2'b00)
      $display("FAIL auto_quiet got %b want 00", {busy, overrun});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bad;
    count_in = 8'hF0;
    send = 1'b1;
    tick();
    send = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    total_cnt++;
    if ({tx, busy} !== {exp_tx(8'hF0, 17), 1'b1})
      $display("FAIL rstmid_pre got %b want %b", {tx, busy}, {exp_tx(8'hF0, 17), 1'b1});
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({tx, busy} !== 2'b10)
      $display("FAIL rstmid_async got %b want 10", {tx, busy});
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL rstmid_resume got %0d bad cycles want 0", bad);
    else pass_cnt++;
    count_in = 8'h81;
    send = 1'b1;
    tick();
    send = 1'b0;
    total_cnt++;
    if ({tx, busy} !== 2'b01)
      $display("FAIL rstmid_restart got %b want 01", {tx, busy});
    else pass_cnt++;
    for (int k = 0; k < FRAME; k++) tick();
    total_cnt++;
    if ({tx, busy, done} !== 3'b101)
      $display("FAIL rstmid_done got %b want 101", {tx, busy, done});
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int  n;
    int  dones;
    logic e;
    logic d;
    count_in = 8'h00;
    send = 1'b1;
    tick();
    dones = 0;
    for (int t = 0; t <= 3 * FRAME; t++) begin
      e = exp_tx(8'h00, t % FRAME);
      d = (t > 0) && (t % FRAME == 0);
      if (done) dones++;
      total_cnt++;
      if ({tx, busy, done} !== {e, 1'b1, d})
        $display("FAIL b2b t=%0d got %b want %b", t, {tx, busy, done}, {e, 1'b1, d});
      else pass_cnt++;
      if (t < 3 * FRAME) tick();
    end
    total_cnt++;
    if (dones !== 3) $display("FAIL b2b_count got %0d want 3", dones);
    else pass_cnt++;
    send = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy && n < 100);
    total_cnt++;
    if (n !== FRAME || done !== 1'b1)
      $display("FAIL b2b_last got %0d done=%b want %0d done=1", n, done, FRAME);
    else pass_cnt++;
    total_cnt++;
    if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mid_change();
    test_overrun();
    test_auto();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
